// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N     = 4;
  localparam int DEF_BURST = 4;

  // Two-state arbiter FSM, kept as plain constants for legacy tools.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  // Width of a requester index; never zero, even for a single requester.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side and FIFO-side signals of the arbiter bundled into one interface.
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) ();

  localparam int IW = idx_width(N);

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               fifo_full;
  logic               fifo_we;
  logic [WIDTH-1:0]   fifo_wdata;
  logic               grant_valid;
  logic [IW-1:0]      grant_idx;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_we, fifo_wdata, grant_valid, grant_idx
  );

  // Producers plus FIFO side.
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_we, fifo_wdata, grant_valid, grant_idx
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_valid_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand_idx [N];
  logic [N-1:0]  rot_valid;

  // Candidate index for each search offset, wrapped modulo N.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0] sum;
    assign sum           = {1'b0, rr_ptr_i} + (IW+1)'(gi);
    assign cand_idx[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    assign rot_valid[gi] = req_valid_i[cand_idx[gi]];
  end

  // Scan from the far end so the smallest offset overwrites last and wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        any_o = 1'b1;
        idx_o = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among N producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int BURST = DEF_BURST
) (
  input logic                 clk,
  input logic                 rst,
  fifo_write_arbiter_if.master bus
);

  localparam int IW = idx_width(N);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          busy;
  logic          owner_valid;
  logic          transfer;
  logic [IW-1:0] owner_next;
  logic [WIDTH-1:0] slice [N];

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .any_o       (pick_any),
    .idx_o       (pick_idx)
  );

  // Per-requester data slices, so the owner mux is a plain array select.
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign slice[gi] = bus.req_data[gi*WIDTH +: WIDTH];
  end

  // A word presented while reset is asserted is never accepted.
  assign busy        = (state_q == ST_BUSY);
  assign owner_valid = bus.req_valid[owner_q];
  assign transfer    = busy & owner_valid & ~bus.fifo_full & ~rst;
  assign owner_next  = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

  assign bus.fifo_we     = transfer;
  assign bus.fifo_wdata  = transfer ? slice[owner_q] : '0;
  assign bus.grant_valid = busy;
  assign bus.grant_idx   = owner_q;

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    bus.req_ready = '0;
    if (busy && !rst) begin
      bus.req_ready[owner_q] = ~bus.fifo_full;
    end
  end

  // Grant/release decisions; a dropped owner valid releases even under back-pressure.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == ST_IDLE) begin
      if (pick_any) begin
        owner_d     = pick_idx;
        burst_cnt_d = '0;
        state_d     = ST_BUSY;
      end
    end else begin
      if (!owner_valid) begin
        state_d  = ST_IDLE;
        rr_ptr_d = owner_next;
      end else if (transfer) begin
        if (burst_cnt_q == LAST_BEAT) begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner_next;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (WIDTH=16, N=4, BURST=4).
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

  fifo_write_arbiter #(.WIDTH(WIDTH), .N(N), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Producer model: requester i offers base[i]+k[i] while enabled and k[i] < limit[i].
  logic [N-1:0] en;
  logic         full_in;
  int           base  [N];
  int           k     [N];
  int           limit [N];

  // Outputs sampled mid-cycle.
  logic         we_s;
  logic [15:0]  wd_s;
  logic [N-1:0] rdy_s;
  logic         gv_s;
  logic [1:0]   gi_s;

  // One clock cycle: drive inputs, sample outputs, cross the edge, advance producers.
  task automatic tick();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = en[i] && (k[i] < limit[i]);
      bus.req_data[i*WIDTH +: WIDTH] = 16'(base[i] + k[i]);
    end
    bus.fifo_full = full_in;
    #1;
    we_s  = bus.fifo_we;
    wd_s  = bus.fifo_wdata;
    rdy_s = bus.req_ready;
    gv_s  = bus.grant_valid;
    gi_s  = bus.grant_idx;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && rdy_s[i]) k[i]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0;
    full_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      k[i] = 0; base[i] = 0; limit[i] = 1000;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    full_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      k[i] = 0; base[i] = i * 16 + 5; limit[i] = 1000;
    end
    en = 4'b1111;
    tick();
    tick();
    n_checks++; if (gv_s !== 1'b0) begin n_fail++; $display("FAIL reset_gv: got %0b expected 0", gv_s); end
    n_checks++; if (we_s !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b expected 0", we_s); end
    n_checks++; if (rdy_s !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", rdy_s); end
    rst = 1'b0;
    tick();
    n_checks++; if (gv_s !== 1'b0 || gi_s !== 2'd0 || we_s !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got gv=%0b gi=%0d we=%0b expected gv=0 gi=0 we=0", gv_s, gi_s, we_s); end
    tick();
    n_checks++; if (gv_s !== 1'b1 || gi_s !== 2'd0) begin n_fail++; $display("FAIL reset_first_grant: got gv=%0b gi=%0d expected gv=1 gi=0", gv_s, gi_s); end
    n_checks++; if (we_s !== 1'b1 || wd_s !== 16'd5) begin n_fail++; $display("FAIL reset_first_word: got we=%0b wd=%0d expected we=1 wd=5", we_s, wd_s); end
  endtask

  task automatic test_single();
    logic       exp_we;
    logic [15:0] exp_wd;
    do_reset();
    en = 4'b0100; base[2] = 1; limit[2] = 8;
    for (int t = 0; t < 12; t++) begin
      tick();
      exp_we = (t >= 1 && t <= 4) || (t >= 6 && t <= 9);
      exp_wd = !exp_we ? 16'd0 : (t <= 4) ? 16'(t) : 16'(t - 1);
      n_checks++; if (we_s !== exp_we || wd_s !== exp_wd) begin n_fail++; $display("FAIL single_write t=%0d: got we=%0b wd=%0d expected we=%0b wd=%0d", t, we_s, wd_s, exp_we, exp_wd); end
      n_checks++; if (gv_s !== exp_we || (exp_we && gi_s !== 2'd2)) begin n_fail++; $display("FAIL single_grant t=%0d: got gv=%0b gi=%0d expected gv=%0b gi=2", t, gv_s, gi_s, exp_we); end
    end
  endtask

  task automatic test_round_robin();
    logic        exp_we;
    int          b, p, owner;
    logic [15:0] exp_wd;
    do_reset();
    en = 4'b1111;
    for (int i = 0; i < N; i++) base[i] = i * 16;
    for (int t = 0; t < 25; t++) begin
      tick();
      b = t / 5; p = t % 5; owner = b % 4;
      exp_we = (p != 0);
      exp_wd = exp_we ? 16'(owner * 16 + (b / 4) * 4 + p - 1) : 16'd0;
      n_checks++; if (we_s !== exp_we || wd_s !== exp_wd) begin n_fail++; $display("FAIL rr_write t=%0d: got we=%0b wd=%0d expected we=%0b wd=%0d", t, we_s, wd_s, exp_we, exp_wd); end
      if (exp_we) begin
        n_checks++; if (gi_s !== 2'(owner)) begin n_fail++; $display("FAIL rr_owner t=%0d: got gi=%0d expected %0d", t, gi_s, owner); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic        exp_we;
    logic [15:0] exp_wd;
    do_reset();
    en = 4'b0010; base[1] = 100; limit[1] = 8;
    for (int t = 0; t < 12; t++) begin
      full_in = (t >= 3 && t <= 7);
      tick();
      exp_we = (t == 1 || t == 2 || t == 8 || t == 9 || t == 11);
      exp_wd = (t == 1) ? 16'd100 : (t == 2) ? 16'd101 : (t == 8) ? 16'd102 :
               (t == 9) ? 16'd103 : (t == 11) ? 16'd104 : 16'd0;
      n_checks++; if (we_s !== exp_we || wd_s !== exp_wd) begin n_fail++; $display("FAIL bp_write t=%0d: got we=%0b wd=%0d expected we=%0b wd=%0d", t, we_s, wd_s, exp_we, exp_wd); end
      if (t >= 3 && t <= 7) begin
        n_checks++; if (rdy_s !== 4'b0000 || gv_s !== 1'b1 || gi_s !== 2'd1) begin n_fail++; $display("FAIL bp_stall t=%0d: got rdy=%b gv=%0b gi=%0d expected rdy=0000 gv=1 gi=1", t, rdy_s, gv_s, gi_s); end
      end
      if (t == 10) begin
        n_checks++; if (gv_s !== 1'b0) begin n_fail++; $display("FAIL bp_release: got gv=%0b expected 0", gv_s); end
      end
    end
    full_in = 1'b0;
  endtask

  task automatic test_early_release();
    int          exp_owner;
    logic [15:0] exp_wd;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      en = 4'b1000; base[3] = 70; limit[3] = 1; base[0] = 80; base[1] = 90;
      tick();
      n_checks++; if (we_s !== 1'b0) begin n_fail++; $display("FAIL early_bubble s=%0d: got we=%0b expected 0", s, we_s); end
      tick();
      n_checks++; if (we_s !== 1'b1 || wd_s !== 16'd70 || gi_s !== 2'd3) begin n_fail++; $display("FAIL early_word s=%0d: got we=%0b wd=%0d gi=%0d expected we=1 wd=70 gi=3", s, we_s, wd_s, gi_s); end
      en = (s == 0) ? 4'b1011 : 4'b1010;
      full_in = (s == 1);
      tick();
      n_checks++; if (we_s !== 1'b0 || gv_s !== 1'b1) begin n_fail++; $display("FAIL early_drop s=%0d: got we=%0b gv=%0b expected we=0 gv=1", s, we_s, gv_s); end
      full_in = 1'b0;
      tick();
      n_checks++; if (gv_s !== 1'b0 || we_s !== 1'b0) begin n_fail++; $display("FAIL early_idle s=%0d: got gv=%0b we=%0b expected gv=0 we=0", s, gv_s, we_s); end
      tick();
      exp_owner = (s == 0) ? 0 : 1;
      exp_wd    = (s == 0) ? 16'd80 : 16'd90;
      n_checks++; if (gv_s !== 1'b1 || gi_s !== 2'(exp_owner) || we_s !== 1'b1 || wd_s !== exp_wd) begin n_fail++; $display("FAIL early_next s=%0d: got gv=%0b gi=%0d we=%0b wd=%0d expected gv=1 gi=%0d we=1 wd=%0d", s, gv_s, gi_s, we_s, wd_s, exp_owner, exp_wd); end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    en = 4'b0100; base[2] = 200; limit[2] = 8; base[0] = 50;
    tick();
    tick();
    n_checks++; if (we_s !== 1'b1 || wd_s !== 16'd200) begin n_fail++; $display("FAIL rmb_word0: got we=%0b wd=%0d expected we=1 wd=200", we_s, wd_s); end
    tick();
    n_checks++; if (we_s !== 1'b1 || wd_s !== 16'd201) begin n_fail++; $display("FAIL rmb_word1: got we=%0b wd=%0d expected we=1 wd=201", we_s, wd_s); end
    rst = 1'b1;
    tick();
    n_checks++; if (we_s !== 1'b0 || rdy_s !== 4'b0000) begin n_fail++; $display("FAIL rmb_in_reset: got we=%0b rdy=%b expected we=0 rdy=0000", we_s, rdy_s); end
    rst = 1'b0;
    en = 4'b0101;
    tick();
    n_checks++; if (gv_s !== 1'b0 || gi_s !== 2'd0 || we_s !== 1'b0) begin n_fail++; $display("FAIL rmb_idle: got gv=%0b gi=%0d we=%0b expected gv=0 gi=0 we=0", gv_s, gi_s, we_s); end
    tick();
    n_checks++; if (gv_s !== 1'b1 || gi_s !== 2'd0 || we_s !== 1'b1 || wd_s !== 16'd50) begin n_fail++; $display("FAIL rmb_regrant: got gv=%0b gi=%0d we=%0b wd=%0d expected gv=1 gi=0 we=1 wd=50", gv_s, gi_s, we_s, wd_s); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the 16-bit FIFO (data_in/we/fifo_full) between N producers.
- Uses round-robin grant with a bounded burst length, so no producer can monopolise the FIFO.
- Sits directly in front of the FIFO: its fifo_we/fifo_wdata drive FIFO we/data_in, and FIFO fifo_full feeds back in.
- The FIFO read side is untouched.

Parameters:
- WIDTH, 16, data word width; must match FIFO width.
- N, 4, number of requesters (2..8).
- BURST, 4, maximum words accepted per grant (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N  requester i has a word on its data slice.
- req_data  input  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- req_ready  output  N  word of requester i accepted this cycle when valid&ready.
- fifo_full  input  1  FIFO full flag.
- fifo_we  output  1  FIFO write enable.
- fifo_wdata  output  WIDTH  FIFO write data.
- grant_valid  output  1  registered: an owner currently holds the port.
- grant_idx  output  $clog2(N)  registered: current owner index.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst=1 at a rising edge) sets state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
  - Resulting outputs: grant_valid=0, grant_idx=0, req_ready=0, fifo_we=0, fifo_wdata=0.
  - Reset mid-burst aborts the burst; words not yet accepted are not written.
- States: IDLE, BUSY.
- IDLE:
  - req_ready=0, fifo_we=0.
  - If any req_valid: owner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N. Then burst_cnt=0, go to BUSY.
  - If no req_valid: stay in IDLE, rr_ptr unchanged.
  - This gives one arbitration bubble cycle per grant.
- BUSY:
  - req_ready[owner] = ~fifo_full; all other ready bits are 0 (combinational).
  - Transfer = req_valid[owner] & ~fifo_full. In a transfer cycle: fifo_we=1, fifo_wdata = owner slice (zero-latency passthrough), burst_cnt++.
  - fifo_wdata = 0 whenever fifo_we=0.
- Release from BUSY to IDLE, with rr_ptr = (owner+1) mod N, occurs when either:
  - a transfer happens with burst_cnt==BURST-1, or
  - req_valid[owner]==0 in any BUSY cycle; no write occurs that cycle.
- fifo_full in BUSY: stall. No write, burst_cnt held, grant held indefinitely while the owner stays valid. There is no timeout.
- Owner drops valid while fifo_full: release (the valid-drop rule has priority).
- Non-owner valid changes never affect the current burst.
- BURST=1: every grant carries exactly one word, giving strict alternation among active requesters.
- Word order within one requester is preserved. Interleaving between requesters happens only at burst boundaries.
- The arbiter never asserts fifo_we in a cycle where fifo_full=1.
- burst_cnt width is $clog2(BURST+1) and it never wraps past BURST-1.
- rr_ptr wraps N-1 to 0.

Decomposition:
- Package fifo_arb_pkg holds:
  - default WIDTH/N/BURST constants;
  - the state typedef/encoding (IDLE=0, BUSY=1);
  - an index width function.
- One sub-module, rr_pick: combinational rotate/find-first.
  - Inputs: req_valid, rr_ptr.
  - Outputs: any, idx.
  - Instantiated once in the arbiter.

Test Plan:
- Reset: hold rst=1 for 2 cycles while req_valid=4'b1111 -> grant_valid=0, fifo_we=0, req_ready=0. On release, grant_idx=0 after 1 cycle.
- Single requester: req_valid=4'b0100 streaming data 1..8, fifo_full=0 -> two bursts of 4. Writes are 1,2,3,4, then 1 idle cycle, then 5,6,7,8. grant_idx=2 throughout.
- Round robin: all four valid continuously, each sending i*16+k -> FIFO write order is bursts from 0,1,2,3,0 with one bubble between bursts. rr_ptr returns to 0 after the 4th burst.
- Back-pressure: owner 1 mid-burst after 2 words, assert fifo_full for 5 cycles -> fifo_we=0 and req_ready=0 for those 5 cycles. burst_cnt stays 2; the remaining 2 words are written after fifo_full falls.
- Early release: owner 3 drops valid after 1 word -> return to IDLE. Next grant goes to 0 if valid, else the next valid index.
- Reset mid-burst: rst=1 after owner 2 has written 2 words -> state IDLE, rr_ptr=0, no further writes until re-arbitration. The next grant starts from index 0.
